// File: rtl/flash_read_responder.sv
// Read responder for the flash read handshake: stalls the master, accepts one
// address per grant, fetches from synchronous storage and returns the word at fixed latency.
module flash_read_responder #(
  parameter int ADDR_WIDTH   = 23,
  parameter int DATA_WIDTH   = 32,
  parameter int WAIT_CYCLES  = 2,
  parameter int READ_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  wait_request,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  data_valid,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [15:0]           served_count,
  output logic [1:0]            state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;

  localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam int PD        = (READ_LATENCY > 2) ? READ_LATENCY - 2 : 1;

  logic [1:0]            state_nxt;
  logic [3:0]            stall_cnt;
  logic [3:0]            stall_cnt_nxt;
  logic                  accept;
  logic                  rdata_ok;
  logic                  src_v;
  logic [DATA_WIDTH-1:0] src_d;
  logic                  pipe_any;

  assign accept = (state == GRANT) && read;

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    case (state)
      IDLE: begin
        if (read) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt     = STALL;
            stall_cnt_nxt = 4'(WAIT_LOAD);
          end else begin
            state_nxt = GRANT;
          end
        end
      end
      STALL: begin
        if (!read) begin
          state_nxt = IDLE;
        end else if (stall_cnt == 4'd0) begin
          state_nxt = GRANT;
        end else begin
          stall_cnt_nxt = stall_cnt - 4'd1;
        end
      end
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rdata_ok marks the cycle in which mem_rdata holds the requested word;
  // the extra stages below stretch that to the configured latency.
  generate
    if (READ_LATENCY > 2) begin : g_pipe
      logic [PD-1:0]         pv;
      logic [DATA_WIDTH-1:0] pd [PD];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          pv <= '0;
        end else begin
          pv[0] <= rdata_ok;
          for (int i = 1; i < PD; i++) pv[i] <= pv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        pd[0] <= mem_rdata;
        for (int i = 1; i < PD; i++) pd[i] <= pd[i-1];
      end

      assign src_v    = pv[PD-1];
      assign src_d    = pd[PD-1];
      assign pipe_any = |pv;
    end else begin : g_direct
      assign src_v    = rdata_ok;
      assign src_d    = mem_rdata;
      assign pipe_any = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      stall_cnt    <= 4'd0;
      wait_request <= 1'b1;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      rdata_ok     <= 1'b0;
      data_valid   <= 1'b0;
      read_data    <= '0;
      busy         <= 1'b0;
      served_count <= 16'd0;
    end else begin
      state        <= state_nxt;
      stall_cnt    <= stall_cnt_nxt;
      wait_request <= (state_nxt != GRANT);
      mem_rd_en    <= accept;
      if (accept) mem_addr <= address;
      rdata_ok     <= mem_rd_en;
      data_valid   <= src_v;
      if (src_v) read_data <= src_d;
      // Stays high through the cycle of the last data_valid pulse.
      busy         <= accept | mem_rd_en | rdata_ok | pipe_any;
      served_count <= served_count + {15'd0, src_v};
    end
  end

endmodule
